// File: rtl/sdp_ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM with hardware clear.
// Optional output pipeline register: define SDP_RAM_OUTREG_EN.
package sdp_ram_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_INIT = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;

`ifdef SDP_RAM_OUTREG_EN
   localparam int RD_LATENCY = 2;
`else
   localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/sdp_ram_core.sv
// Bare simple-dual-port array: write port A, registered read port B.
// The array itself has no reset so it maps onto block RAM; only the read
// register is reset. Out-of-range writes are dropped and out-of-range reads
// return zero, which matters when DEPTH is not a power of two.
module sdp_ram_core
   import sdp_ram_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int RDW_MODE = RDW_WRITE_FIRST
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              we,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] din,
   input  logic              re,
   input  logic [ADDR_W-1:0] addrb,
   output logic [DATA_W-1:0] dout
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic              rd_ok;
   logic              collide;

   assign wr_ok   = ({1'b0, addra} < DEPTH_L);
   assign rd_ok   = ({1'b0, addrb} < DEPTH_L);
   assign collide = we && wr_ok && (addra == addrb);

   // write port: in-range addresses only
   always_ff @(posedge CLK) begin
      if (we && wr_ok) begin
         mem[addra] <= din;
      end
   end

   // read port: registered, holds when not enabled; bypass gives write-first
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dout <= '0;
      end else if (re) begin
         if (!rd_ok) begin
            dout <= '0;
         end else if ((RDW_MODE == RDW_WRITE_FIRST) && collide) begin
            dout <= din;
         end else begin
            dout <= mem[addrb];
         end
      end
   end

endmodule

// File: rtl/sdp_ram_init.sv
// Parametrised simple-dual-port RAM with post-reset clear sweep and read strobe.
// Optional feature macro: SDP_RAM_OUTREG_EN adds an output pipeline register
// (DOB/DOB_VALID at read edge + 2).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | clear sweep: writes 0 to address cnt each cycle, user blocked
// ST_RUN  | normal operation, terminal until next reset
module sdp_ram_init
   import sdp_ram_pkg::*;
#(
   parameter int DATA_W         = 4,
   parameter int ADDR_W         = 8,
   parameter int DEPTH          = 256,
   parameter int CLEAR_ON_RESET = 1,
   parameter int RDW_MODE       = RDW_WRITE_FIRST
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              WEA,
   input  logic [ADDR_W-1:0] ADDRA,
   input  logic [DATA_W-1:0] DIA,
   input  logic              REB,
   input  logic [ADDR_W-1:0] ADDRB,
   output logic [DATA_W-1:0] DOB,
   output logic              DOB_VALID,
   output logic              INIT_BUSY
);

   localparam state_t            ST_AFTER_RST = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              in_init;
   logic              core_we;
   logic [ADDR_W-1:0] core_addra;
   logic [DATA_W-1:0] core_din;
   logic              core_re;
   logic [DATA_W-1:0] core_dout;
   logic              rd_vld;

   assign in_init   = (state == ST_INIT);
   assign INIT_BUSY = in_init;

   // clear sweep owns port A while it runs; user reads are gated off
   assign core_we    = in_init ? 1'b1 : WEA;
   assign core_addra = in_init ? cnt  : ADDRA;
   assign core_din   = in_init ? '0   : DIA;
   assign core_re    = REB && !in_init;

   // clear FSM and address counter; a reset always restarts from address 0
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_AFTER_RST;
         cnt   <= '0;
      end else if (state == ST_INIT) begin
         if (cnt == LAST_ADDR) begin
            state <= ST_RUN;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   sdp_ram_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .CLK   (CLK),
      .RST_N (RST_N),
      .we    (core_we),
      .addra (core_addra),
      .din   (core_din),
      .re    (core_re),
      .addrb (ADDRB),
      .dout  (core_dout)
   );

   // one strobe per accepted read, aligned with the array output register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_vld <= 1'b0;
      end else begin
         rd_vld <= core_re;
      end
   end

`ifdef SDP_RAM_OUTREG_EN
   logic [DATA_W-1:0] dob_q;
   logic              dob_vld_q;

   // extra output stage; data only moves on a valid so DOB holds otherwise
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dob_q     <= '0;
         dob_vld_q <= 1'b0;
      end else begin
         dob_vld_q <= rd_vld;
         if (rd_vld) begin
            dob_q <= core_dout;
         end
      end
   end

   assign DOB       = dob_q;
   assign DOB_VALID = dob_vld_q;
`else
   assign DOB       = core_dout;
   assign DOB_VALID = rd_vld;
`endif

endmodule
